// File: rtl/enc8x3_seq_if.sv
// rtl/enc8x3_seq_if.sv - request/handshake bundle for the sequential 8-to-3 encoder
//
// Signals:
//   A     8  request vector into the encoder
//   ready 1  consumer accepts Y when ready && valid
//   Y     3  served index (registered)
//   valid 1  Y holds a served index (registered)
//   pend  8  pending request set, excluding the bit currently being served
//   idle  1  pend == 0 and valid == 0
// Modports: slave = encoder side, master = requester/consumer side.
interface enc8x3_seq_if;
  logic [7:0] A;
  logic       ready;
  logic [2:0] Y;
  logic       valid;
  logic [7:0] pend;
  logic       idle;

  modport slave (
    input  A,
    input  ready,
    output Y,
    output valid,
    output pend,
    output idle
  );

  modport master (
    output A,
    output ready,
    input  Y,
    input  valid,
    input  pend,
    input  idle
  );
endinterface

// File: rtl/enc8x3_seq.sv
// rtl/enc8x3_seq.sv - sequential 8-to-3 encoder serving pending requests one index per handshake
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  enc8x3_seq_if.slave (A, ready in; Y, valid, pend, idle out)
// Parameter:
//   HIGH_FIRST  1 = bit 7 has highest priority, 0 = bit 0 has highest priority
// Optional feature macro: ENC8X3_ROUND_ROBIN_EN
//   defined   -> rotating priority starting after the last granted index (HIGH_FIRST ignored)
//   undefined -> fixed priority per HIGH_FIRST
module enc8x3_seq #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  enc8x3_seq_if.slave  bus
);

  logic [7:0] pend_q;
  logic [2:0] y_q;
  logic       valid_q;
  logic [7:0] merged;
  logic       can_advance;
  logic [2:0] sel;

`ifdef ENC8X3_ROUND_ROBIN_EN
  logic [2:0] last_q;
`endif

  // New requests fold into the pending set every edge; a bit already
  // pending or re-asserted as it is granted simply merges, never duplicates.
  assign merged      = pend_q | bus.A;
  assign can_advance = !valid_q || bus.ready;

  always_comb begin
    sel = 3'd0;
`ifdef ENC8X3_ROUND_ROBIN_EN
    // Walk offsets from farthest to nearest so the nearest set bit after
    // last_q wins; offset 8 wraps back onto last_q itself.
    for (int k = 8; k >= 1; k--) begin
      if (merged[3'(last_q + 3'(k))]) sel = 3'(last_q + 3'(k));
    end
`else
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (merged[i]) sel = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (merged[i]) sel = 3'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 8'h00;
      y_q     <= 3'd0;
      valid_q <= 1'b0;
`ifdef ENC8X3_ROUND_ROBIN_EN
      last_q  <= 3'd7;
`endif
    end else if (can_advance) begin
      if (merged != 8'h00) begin
        y_q     <= sel;
        valid_q <= 1'b1;
        pend_q  <= merged & ~(8'b1 << sel);
`ifdef ENC8X3_ROUND_ROBIN_EN
        last_q  <= sel;
`endif
      end else begin
        // Nothing to serve: drop valid, keep Y at its last value.
        valid_q <= 1'b0;
        pend_q  <= 8'h00;
      end
    end else begin
      // Stall: the offered index holds while requests keep accumulating.
      pend_q <= merged;
    end
  end

  assign bus.Y     = y_q;
  assign bus.valid = valid_q;
  assign bus.pend  = pend_q;
  assign bus.idle  = (pend_q == 8'h00) && !valid_q;

endmodule
